// File: rtl/xpb_accumulator.sv
// rtl/xpb_accumulator.sv - accumulates xpb0/xpb1 limb-vector beats and ripple-normalizes the total
// Guard-extended limbs absorb up to MAX_TERMS beats; one limb is normalized per NORM cycle.
module xpb_accumulator #(
   parameter int NUM_XPB     = 38,
   parameter int BIT_LEN_XPB = 27,
   parameter int GUARD_BITS  = 4,
   parameter int MAX_TERMS   = 8
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic                                 in_last,
   input  logic [NUM_XPB*BIT_LEN_XPB-1:0]       xpb0,
   input  logic [NUM_XPB*BIT_LEN_XPB-1:0]       xpb1,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [(NUM_XPB+1)*BIT_LEN_XPB-1:0]   out_sum,
   output logic                                 out_overflow,
   output logic                                 out_term_err
);

   localparam int ACC_W   = BIT_LEN_XPB + GUARD_BITS;
   localparam int CARRY_W = ACC_W + 1 - BIT_LEN_XPB;
   localparam int IDX_W   = $clog2(NUM_XPB + 1);
   localparam int CNT_W   = $clog2(MAX_TERMS + 1);

   typedef enum logic [1:0] {ACCUM, NORM, OUT} state_t;

   state_t             state;
   logic [ACC_W-1:0]   acc      [0:NUM_XPB];
   logic [ACC_W-1:0]   beat_sum [0:NUM_XPB];
   logic [CNT_W-1:0]   term_cnt;
   logic [CNT_W-1:0]   term_nxt;
   logic [CARRY_W-1:0] carry;
   logic [IDX_W-1:0]   k;
   logic               err;
   logic [ACC_W:0]     norm_s;

   // xpb1 limb i lands one limb higher, so acc[NUM_XPB] only ever sees xpb1's top limb.
   always_comb begin
      for (int i = 0; i <= NUM_XPB; i++) begin
         beat_sum[i] = acc[i];
      end
      for (int i = 0; i < NUM_XPB; i++) begin
         beat_sum[i]   = beat_sum[i]   + ACC_W'(xpb0[i*BIT_LEN_XPB +: BIT_LEN_XPB]);
         beat_sum[i+1] = beat_sum[i+1] + ACC_W'(xpb1[i*BIT_LEN_XPB +: BIT_LEN_XPB]);
      end
   end

   assign term_nxt = term_cnt + CNT_W'(1);
   assign norm_s   = {1'b0, acc[k]} + (ACC_W+1)'(carry);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ACCUM;
         for (int i = 0; i <= NUM_XPB; i++) acc[i] <= '0;
         out_sum      <= '0;
         term_cnt     <= '0;
         carry        <= '0;
         k            <= '0;
         err          <= 1'b0;
         in_ready     <= 1'b1;
         out_valid    <= 1'b0;
         out_overflow <= 1'b0;
         out_term_err <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (in_valid && in_ready) begin
                  for (int i = 0; i <= NUM_XPB; i++) acc[i] <= beat_sum[i];
                  term_cnt <= term_nxt;
                  if (in_last || term_nxt == CNT_W'(MAX_TERMS)) begin
                     state    <= NORM;
                     in_ready <= 1'b0;
                     k        <= '0;
                     carry    <= '0;
                     err      <= ~in_last;
                  end
               end
            end
            NORM: begin
               out_sum[k*BIT_LEN_XPB +: BIT_LEN_XPB] <= norm_s[BIT_LEN_XPB-1:0];
               carry <= norm_s[ACC_W:BIT_LEN_XPB];
               if (k == IDX_W'(NUM_XPB)) begin
                  out_overflow <= |norm_s[ACC_W:BIT_LEN_XPB];
                  out_term_err <= err;
                  out_valid    <= 1'b1;
                  state        <= OUT;
               end else begin
                  k <= k + IDX_W'(1);
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  for (int i = 0; i <= NUM_XPB; i++) acc[i] <= '0;
                  term_cnt  <= '0;
                  err       <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_xpb_accumulator.sv
// tb/tb_xpb_accumulator.sv - directed scoreboard bench for xpb_accumulator
// Expected results come from a wide-integer model of sum(xpb0 + xpb1 * 2^27).
module tb_xpb_accumulator;

   localparam int NX = 38;
   localparam int BL = 27;
   localparam int VW = NX * BL;
   localparam int SW = (NX + 1) * BL;
   localparam int MW = SW + 7;

   typedef struct {
      logic [SW-1:0] sum;
      logic          ovf;
      logic          terr;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          in_last = 1'b0;
   logic [VW-1:0] xpb0 = '0;
   logic [VW-1:0] xpb1 = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [SW-1:0] out_sum;
   logic          out_overflow;
   logic          out_term_err;

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            accept_cyc = 0;
   logic [MW-1:0] model_total = '0;
   int            model_cnt = 0;
   exp_t          sb[$];
   logic [VW-1:0] v0, v1;

   xpb_accumulator dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_last(in_last), .xpb0(xpb0), .xpb1(xpb1), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_overflow(out_overflow),
      .out_term_err(out_term_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_accept(input logic [VW-1:0] x0, input logic [VW-1:0] x1, input logic last);
      exp_t e;
      model_total = model_total + MW'(x0) + (MW'(x1) << BL);
      model_cnt++;
      if (last || model_cnt == 8) begin
         e.sum  = model_total[SW-1:0];
         e.ovf  = |model_total[MW-1:SW];
         e.terr = ~last;
         sb.push_back(e);
         model_total = '0;
         model_cnt = 0;
      end
   endtask

   // Called just after a negedge; returns just after the negedge following the accept edge.
   task automatic send_beat(input logic [VW-1:0] x0, input logic [VW-1:0] x1, input logic last);
      int n = 0;
      xpb0 = x0; xpb1 = x1; in_last = last; in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("accept_timeout", 32'(in_ready), 32'd1);
      if (in_ready === 1'b1) begin
         @(posedge clk);
         model_accept(x0, x1, last);
         @(negedge clk);
         accept_cyc = cyc;
      end
      in_valid = 1'b0;
   endtask

   task automatic collect(input string tag, input int hold);
      int n = 0;
      exp_t e;
      logic [SW-1:0] held;
      while (out_valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid_seen"}, 32'(out_valid), 32'd1);
      if (out_valid !== 1'b1) return;
      chk({tag, "_latency"}, 32'(cyc - accept_cyc), 32'd39);
      held = out_sum;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk($sformatf("%s_hold%0d_in_ready", tag, h), 32'(in_ready), 32'd0);
         chk($sformatf("%s_hold%0d_valid", tag, h), 32'(out_valid), 32'd1);
         chk($sformatf("%s_hold%0d_stable", tag, h), 32'(out_sum === held), 32'd1);
      end
      chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         for (int l = 0; l <= NX; l++)
            chk($sformatf("%s_sum[%0d]", tag, l), 32'(out_sum[l*BL +: BL]), 32'(e.sum[l*BL +: BL]));
         chk({tag, "_overflow"}, 32'(out_overflow), 32'(e.ovf));
         chk({tag, "_term_err"}, 32'(out_term_err), 32'(e.terr));
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_valid_dropped"}, 32'(out_valid), 32'd0);
      chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int stray;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_overflow", 32'(out_overflow), 32'd0);
      chk("rst_term_err", 32'(out_term_err), 32'd0);
      chk("rst_sum_zero", 32'(|out_sum), 32'd0);

      v0 = '0; v1 = '0; v0[0 +: BL] = 27'd1;
      send_beat(v0, v1, 1'b1);
      collect("single", 0);

      v0 = '0; v0[0 +: BL] = 27'h7FFFFFF;
      send_beat(v0, v1, 1'b0);
      send_beat(v0, v1, 1'b1);
      collect("carry0", 0);

      v0 = '0; v1 = '0; v1[0 +: BL] = 27'd3; v1[37*BL +: BL] = 27'd5;
      send_beat(v0, v1, 1'b1);
      collect("realign", 0);

      v1 = '0; v1[37*BL +: BL] = 27'h7FFFFFF;
      send_beat(v0, v1, 1'b0);
      send_beat(v0, v1, 1'b1);
      collect("overflow", 0);

      v0 = '0; v1 = '0; v0[0 +: BL] = 27'd1;
      for (int b = 0; b < 8; b++) send_beat(v0, v1, 1'b0);
      xpb0 = v0; xpb1 = v1; in_last = 1'b0; in_valid = 1'b1;
      collect("term_limit", 10);
      send_beat(v0, v1, 1'b0);
      send_beat(v0, v1, 1'b1);
      collect("after_limit", 0);

      v0 = '0; v0[3*BL +: BL] = 27'd9;
      send_beat(v0, v1, 1'b1);
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midnorm_rst_valid", 32'(out_valid), 32'd0);
      chk("midnorm_rst_in_ready", 32'(in_ready), 32'd1);
      if (sb.size() != 0) void'(sb.pop_back());
      stray = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) stray++;
      end
      chk("midnorm_no_stray_valid", 32'(stray), 32'd0);
      v0 = '0; v0[5*BL +: BL] = 27'd7;
      send_beat(v0, v1, 1'b1);
      collect("post_rst", 0);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/xpb_accumulator.md
Name: xpb_accumulator

Overview:
- Downstream consumer of the xpb partial-product stage in the modular-square reduction path.
- Accepts a stream of (xpb0, xpb1) limb-vector pairs. Each pair holds the low and high halves of flag × xpb_prime, split at 27 bits per limb.
- Realigns xpb1 up one limb and accumulates every beat into guard-extended limbs.
- After the last beat, ripple-normalizes the total into canonical 27-bit limbs and presents it on a valid/ready output.

Parameters:
- NUM_XPB, 38: limbs per input vector.
- BIT_LEN_XPB, 27: canonical limb width.
- GUARD_BITS, 4: extra accumulator bits per limb. Accumulator limb width is BIT_LEN_XPB+GUARD_BITS = 31.
- MAX_TERMS, 8: maximum beats per accumulation. Must equal 2^(GUARD_BITS-1).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_last  in  1  final beat of the current accumulation.
- xpb0  in  NUM_XPB×BIT_LEN_XPB  low-half partial products; limb i has weight 2^(27i).
- xpb1  in  NUM_XPB×BIT_LEN_XPB  high-half partial products; limb i has weight 2^(27(i+1)).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  (NUM_XPB+1)×BIT_LEN_XPB  normalized sum, 39 limbs.
- out_overflow  out  1  carry remained beyond limb NUM_XPB.
- out_term_err  out  1  accumulation was force-terminated at MAX_TERMS.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=ACCUM; all acc limbs, out_sum, term count, carry and limb index cleared.
  - out_valid=0, out_overflow=0, out_term_err=0; in_ready=1 after the reset edge.
  - Reset takes priority over every event, including mid-NORM and mid-OUT; any partial accumulation is discarded.
- Accumulator: acc[0..NUM_XPB], each 31 bits.
- ACCUM state:
  - in_ready=1. A beat is accepted when in_valid && in_ready at an edge.
  - On each accepted beat: acc[0] += xpb0[0]; acc[i] += xpb0[i] + xpb1[i-1] for i=1..NUM_XPB-1; acc[NUM_XPB] += xpb1[NUM_XPB-1].
  - Each beat increments term_cnt.
  - If in_last=1, or term_cnt reaches MAX_TERMS on this beat: go to NORM with limb index k=0 and carry=0.
  - The error flag is set when term_cnt hits MAX_TERMS and in_last=0.
- NORM state:
  - in_ready=0.
  - Each cycle: s = acc[k] + carry (32 bits); out_sum[k] = s[26:0]; carry = s>>27; k++.
  - After k=NUM_XPB is processed (NUM_XPB+1 = 39 cycles): out_overflow = (carry≠0), out_term_err = error flag, go to OUT.
  - out_valid therefore rises 39 cycles after the edge that accepted the last beat.
- OUT state:
  - out_valid=1, in_ready=0.
  - out_sum and flags are held stable while out_ready=0, indefinitely.
  - When out_valid && out_ready at an edge:
    - out_valid=0.
    - acc, term_cnt and error flag cleared.
    - go to ACCUM; in_ready=1 the next cycle.
  - No input beat is accepted in the same cycle as output handoff.
- Width rules:
  - Each beat adds at most 2·(2^27−1) per limb, so MAX_TERMS=8 beats fit within 31 bits without loss.
  - Carry is at most 5 bits.
- Boundary conditions:
  - in_valid while in_ready=0: ignored; upstream must hold the beat.
  - in_last on the first beat: single-term accumulation.
  - A zero-valued beat still counts toward term_cnt.

Test Plan:
- Single beat, xpb0[0]=1, all other limbs 0, in_last=1 -> out_valid exactly 39 cycles after the accept edge; out_sum[0]=1, all other limbs 0, overflow=0.
- Two beats, each xpb0[0]=0x7FFFFFF, second with in_last -> out_sum[0]=0x7FFFFFE, out_sum[1]=1.
- One beat, xpb1[0]=3, xpb1[37]=5, xpb0 all 0 -> out_sum[1]=3, out_sum[38]=5, out_sum[0]=0.
- Two beats, each xpb1[37]=0x7FFFFFF -> out_sum[38]=0x7FFFFFE, out_overflow=1.
- Nine beats of xpb0[0]=1 with in_last never set:
  - 8th beat forces NORM; out_sum[0]=8, out_term_err=1.
  - in_ready=0 until the result is taken; the 9th beat starts a fresh accumulation.
- Backpressure: out_ready=0 for 10 cycles with in_valid=1 -> in_ready=0 and out_sum stable throughout; handoff on out_ready=1; in_ready=1 the next cycle.
- rst_n=0 for one edge mid-NORM (k=20) -> out_valid=0, in_ready=1 next cycle; a following single beat xpb0[5]=7 yields out_sum[5]=7 with all other limbs 0.
